// File: rtl/sdram_arb_defs.sv
// Shared SDRAM arbitration definitions: grant encodings, ack bit indices, FSM states.
// Used by the slot arbiter and the SDRAM controller.
package sdram_arb_defs;

    typedef enum logic [2:0] {
        GNT_NONE    = 3'd0,
        GNT_CHIP    = 3'd1,
        GNT_AUD     = 3'd2,
        GNT_RTG     = 3'd3,
        GNT_CPU     = 3'd4,
        GNT_HOST    = 3'd5,
        GNT_REFRESH = 3'd7
    } grant_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_e;

    localparam int unsigned ACK_CHIP = 0;
    localparam int unsigned ACK_AUD  = 1;
    localparam int unsigned ACK_RTG  = 2;
    localparam int unsigned ACK_CPU  = 3;
    localparam int unsigned ACK_HOST = 4;
    localparam int unsigned ACK_W    = 5;

    // Refresh and "none" never produce an ack.
    function automatic logic [ACK_W-1:0] ack_onehot(grant_e g);
        logic [ACK_W-1:0] a;
        a = '0;
        case (g)
            GNT_CHIP: a[ACK_CHIP] = 1'b1;
            GNT_AUD:  a[ACK_AUD]  = 1'b1;
            GNT_RTG:  a[ACK_RTG]  = 1'b1;
            GNT_CPU:  a[ACK_CPU]  = 1'b1;
            GNT_HOST: a[ACK_HOST] = 1'b1;
            default:  a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/sdram_slot_arbiter_if.sv
// Request/grant bus between the SDRAM sequencer/requesters and the slot arbiter.
interface sdram_slot_arbiter_if;
    import sdram_arb_defs::*;

    logic             slot_start;
    logic             chip_req;
    logic             aud_req;
    logic             rtg_req;
    logic             cpu_req;
    logic             host_req;
    logic             rtgpri;
    logic [2:0]       grant;
    logic             grant_valid;
    logic [ACK_W-1:0] ack;
    logic             refresh;
    logic             overrun;

    modport master (
        output slot_start, chip_req, aud_req, rtg_req, cpu_req, host_req, rtgpri,
        input  grant, grant_valid, ack, refresh, overrun
    );

    modport slave (
        input  slot_start, chip_req, aud_req, rtg_req, cpu_req, host_req, rtgpri,
        output grant, grant_valid, ack, refresh, overrun
    );
endinterface

// File: rtl/sdram_refresh_timer.sv
// Counts slot boundaries and raises a single (non-queued) refresh request every REFRESH_SLOTS slots.
module sdram_refresh_timer
    import sdram_arb_defs::*;
#(
    parameter int REFRESH_SLOTS = 64
) (
    input  logic sysclk,
    input  logic _reset,
    input  logic slot_start,
    input  logic grant_refresh,
    output logic pending
);

    localparam int CW = (REFRESH_SLOTS > 1) ? $clog2(REFRESH_SLOTS) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = slot_start && (cnt == CW'(REFRESH_SLOTS - 1));

    // A wrap on the same strobe as a refresh grant wins, so the flag stays set.
    always_ff @(posedge sysclk or negedge _reset) begin
        if (!_reset) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            if (slot_start)
                cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                pending <= 1'b1;
            else if (grant_refresh)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// SDRAM slot arbiter: picks one requester (or refresh) per slot boundary and holds it for SLOT_CYCLES.
module sdram_slot_arbiter
    import sdram_arb_defs::*;
#(
    parameter int SLOT_CYCLES   = 16,
    parameter int REFRESH_SLOTS = 64
) (
    input  logic                 sysclk,
    input  logic                 _reset,
    sdram_slot_arbiter_if.slave  bus
);

    localparam int SW = $clog2(SLOT_CYCLES);

    arb_state_e       state_q, state_d;
    grant_e           grant_q, grant_d, winner;
    logic             gv_q, gv_d;
    logic             ref_q, ref_d;
    logic             ovr_q, ovr_d;
    logic             rr_host_q, rr_host_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [ACK_W-1:0] ack_d;
    logic             tie, grant_refresh, refresh_pending;

    sdram_refresh_timer #(
        .REFRESH_SLOTS(REFRESH_SLOTS)
    ) u_refresh_timer (
        .sysclk        (sysclk),
        ._reset        (_reset),
        .slot_start    (bus.slot_start),
        .grant_refresh (grant_refresh),
        .pending       (refresh_pending)
    );

    // Fixed priority among requesters; cpu/host share one tier resolved by round-robin.
    always_comb begin
        winner = GNT_NONE;
        tie    = bus.cpu_req && bus.host_req;
        if (bus.chip_req)                      winner = GNT_CHIP;
        else if (bus.aud_req)                  winner = GNT_AUD;
        else if (bus.rtg_req && bus.rtgpri)    winner = GNT_RTG;
        else if (tie)                          winner = rr_host_q ? GNT_HOST : GNT_CPU;
        else if (bus.cpu_req)                  winner = GNT_CPU;
        else if (bus.host_req)                 winner = GNT_HOST;
        else if (bus.rtg_req)                  winner = GNT_RTG;
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gv_d          = gv_q;
        ref_d         = ref_q;
        rr_host_d     = rr_host_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        grant_refresh = 1'b0;
        ovr_d         = ovr_q || (bus.slot_start && state_q == ST_ACTIVE);
        case (state_q)
            ST_IDLE: begin
                if (bus.slot_start) begin
                    if (refresh_pending) begin
                        grant_refresh = 1'b1;
                        grant_d       = GNT_REFRESH;
                        ref_d         = 1'b1;
                        state_d       = ST_ACTIVE;
                        cnt_d         = SW'(SLOT_CYCLES - 1);
                    end else if (winner != GNT_NONE) begin
                        grant_d = winner;
                        gv_d    = 1'b1;
                        state_d = ST_ACTIVE;
                        cnt_d   = SW'(SLOT_CYCLES - 1);
                        if (tie && (winner == GNT_CPU || winner == GNT_HOST))
                            rr_host_d = ~rr_host_q;
                    end
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == '0) begin
                    ack_d   = ref_q ? '0 : ack_onehot(grant_q);
                    grant_d = GNT_NONE;
                    gv_d    = 1'b0;
                    ref_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge _reset) begin
        if (!_reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= GNT_NONE;
            gv_q      <= 1'b0;
            ref_q     <= 1'b0;
            ovr_q     <= 1'b0;
            rr_host_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gv_q      <= gv_d;
            ref_q     <= ref_d;
            ovr_q     <= ovr_d;
            rr_host_q <= rr_host_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = gv_q;
    assign bus.refresh     = ref_q;
    assign bus.overrun     = ovr_q;
    assign bus.ack         = ack_d;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Scoreboard bench for sdram_slot_arbiter: tests push expected slots, a negedge monitor checks them.
module tb_sdram_slot_arbiter;

    localparam int SLOT = 16;

    typedef struct {
        logic [2:0] grant;
        logic       is_ref;
        logic [4:0] ack;
    } exp_t;

    logic sysclk;
    logic _reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    exp_t cur;
    int   cyc;
    logic trk;
    logic prev_act;
    logic act;

    sdram_slot_arbiter_if bus();

    sdram_slot_arbiter #(
        .SLOT_CYCLES   (SLOT),
        .REFRESH_SLOTS (64)
    ) dut (
        .sysclk (sysclk),
        ._reset (_reset),
        .bus    (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    function automatic logic [4:0] ack_of(input logic [2:0] g);
        logic [4:0] one;
        one = 5'b00001;
        if (g == 3'd0 || g > 3'd5) return 5'b0;
        return one << (g - 3'd1);
    endfunction

    function automatic exp_t mk(input logic [2:0] g);
        exp_t e;
        e.grant  = g;
        e.is_ref = (g == 3'd7);
        e.ack    = ack_of(g);
        return e;
    endfunction

    // Slot monitor: pops one expectation per granted slot, checks grant, ack timing and slot length.
    always @(negedge sysclk) begin
        if (!_reset) begin
            trk      = 1'b0;
            prev_act = 1'b0;
        end else begin
            act = bus.grant_valid | bus.refresh;
            if (act && !prev_act) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL slot_unexpected: grant=%0d refresh=%0b, no slot expected", bus.grant, bus.refresh);
                    cur = mk(bus.grant);
                end else begin
                    cur = exp_q.pop_front();
                    if (bus.grant !== cur.grant || bus.refresh !== cur.is_ref || bus.grant_valid !== !cur.is_ref) begin
                        errors++;
                        $display("FAIL slot_grant: grant=%0d gv=%0b refresh=%0b, expected grant=%0d refresh=%0b",
                                 bus.grant, bus.grant_valid, bus.refresh, cur.grant, cur.is_ref);
                    end
                end
                cyc = 1;
                trk = 1'b1;
            end else if (act && trk) begin
                cyc++;
            end
            if (act && trk) begin
                if (cyc == SLOT) begin
                    checks++;
                    if (bus.ack !== cur.ack) begin
                        errors++;
                        $display("FAIL slot_ack: ack=%b at cycle %0d, expected %b", bus.ack, cyc, cur.ack);
                    end
                end else if (bus.ack !== 5'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL early_ack: ack=%b at cycle %0d, expected 00000", bus.ack, cyc);
                end
            end else if (!act && bus.ack !== 5'b0) begin
                checks++;
                errors++;
                $display("FAIL idle_ack: ack=%b while idle, expected 00000", bus.ack);
            end
            if (!act && prev_act && trk) begin
                checks++;
                if (cyc != SLOT) begin
                    errors++;
                    $display("FAIL slot_length: %0d cycles, expected %0d", cyc, SLOT);
                end
                trk = 1'b0;
            end
            prev_act = act;
        end
    end

    task automatic pulse_slot();
        bus.slot_start = 1'b1;
        @(negedge sysclk);
        bus.slot_start = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sysclk);
            if (!bus.grant_valid && !bus.refresh) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: slot still active after 40 cycles, expected idle");
        end
        @(negedge sysclk);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        _reset = 1'b0;
        @(negedge sysclk);
        _reset = 1'b1;
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        _reset = 1'b0;
        repeat (2) @(negedge sysclk);
        checks++;
        if ({bus.grant, bus.grant_valid, bus.ack, bus.refresh, bus.overrun} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%0d gv=%0b ack=%b refresh=%0b overrun=%0b, expected all 0",
                     bus.grant, bus.grant_valid, bus.ack, bus.refresh, bus.overrun);
        end
        _reset = 1'b1;
        @(negedge sysclk);
    endtask

    task automatic test_priority();
        bus.chip_req = 1'b1; bus.aud_req = 1'b1; bus.cpu_req = 1'b1;
        exp_q.push_back(mk(3'd1));
        pulse_slot();
        wait_idle();
        bus.chip_req = 1'b0;
        exp_q.push_back(mk(3'd2));
        pulse_slot();
        wait_idle();
        bus.aud_req = 1'b0;
        exp_q.push_back(mk(3'd4));
        pulse_slot();
        wait_idle();
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_round_robin();
        bus.cpu_req = 1'b1; bus.host_req = 1'b1;
        for (int s = 0; s < 4; s++) begin
            exp_q.push_back(mk((s % 2 == 0) ? 3'd4 : 3'd5));
            pulse_slot();
            wait_idle();
        end
        bus.cpu_req = 1'b0; bus.host_req = 1'b0;
    endtask

    task automatic test_rtgpri();
        bus.rtg_req = 1'b1; bus.cpu_req = 1'b1; bus.rtgpri = 1'b0;
        exp_q.push_back(mk(3'd4));
        pulse_slot();
        wait_idle();
        bus.rtgpri = 1'b1;
        exp_q.push_back(mk(3'd3));
        pulse_slot();
        wait_idle();
        bus.rtg_req = 1'b0; bus.rtgpri = 1'b0;
        exp_q.push_back(mk(3'd4));
        pulse_slot();
        wait_idle();
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_refresh();
        do_reset();
        for (int s = 0; s < 64; s++) begin
            pulse_slot();
            @(negedge sysclk);
        end
        checks++;
        if (bus.grant !== 3'd0 || bus.grant_valid !== 1'b0 || bus.refresh !== 1'b0) begin
            errors++;
            $display("FAIL idle_slots: grant=%0d gv=%0b refresh=%0b, expected 0 0 0",
                     bus.grant, bus.grant_valid, bus.refresh);
        end
        bus.chip_req = 1'b1;
        exp_q.push_back(mk(3'd7));
        pulse_slot();
        wait_idle();
        exp_q.push_back(mk(3'd1));
        pulse_slot();
        wait_idle();
        bus.chip_req = 1'b0;
    endtask

    task automatic test_overrun();
        bus.aud_req = 1'b1;
        exp_q.push_back(mk(3'd2));
        pulse_slot();
        repeat (7) @(negedge sysclk);
        pulse_slot();
        checks++;
        if (bus.overrun !== 1'b1 || bus.grant !== 3'd2 || bus.grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%0b grant=%0d gv=%0b, expected 1 2 1",
                     bus.overrun, bus.grant, bus.grant_valid);
        end
        wait_idle();
        bus.aud_req = 1'b0;
        checks++;
        if (bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: overrun=%0b, expected 1", bus.overrun);
        end
    endtask

    task automatic test_reset_mid_slot();
        bus.cpu_req = 1'b1;
        exp_q.push_back(mk(3'd4));
        pulse_slot();
        repeat (4) @(negedge sysclk);
        _reset = 1'b0;
        #1;
        checks++;
        if ({bus.grant, bus.grant_valid, bus.ack, bus.refresh, bus.overrun} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid_slot: grant=%0d gv=%0b ack=%b refresh=%0b overrun=%0b, expected all 0",
                     bus.grant, bus.grant_valid, bus.ack, bus.refresh, bus.overrun);
        end
        repeat (2) @(negedge sysclk);
        _reset = 1'b1;
        @(negedge sysclk);
        exp_q.push_back(mk(3'd4));
        pulse_slot();
        wait_idle();
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        trk = 1'b0;
        prev_act = 1'b0;
        cyc = 0;
        _reset = 1'b0;
        bus.slot_start = 1'b0;
        bus.chip_req = 1'b0; bus.aud_req = 1'b0; bus.rtg_req = 1'b0;
        bus.cpu_req = 1'b0;  bus.host_req = 1'b0; bus.rtgpri = 1'b0;

        test_reset();
        test_priority();
        test_round_robin();
        test_rtgpri();
        test_refresh();
        test_overrun();
        test_reset_mid_slot();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_slots: %0d expected slots never granted, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
